// File: rtl/mac_requant.sv
// Requantizer: bias add, per-layer rounding right shift, optional ReLU and 16-bit
// saturation, then a FWFT output FIFO. Define RELU_EN to enable ReLU on conv layers.
module mac_requant #(
  parameter int SHIFT_CONV = 8,
  parameter int SHIFT_FC   = 8,
  parameter int BIAS_SHIFT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] acc,
  input  logic signed [15:0] bias,
  input  logic        [1:0]  layer,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic        [1:0]  out_layer,
  output logic               out_sat,
  output logic        [15:0] sat_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 2;

  logic               s1_valid_reg;
  logic signed [33:0] s1_sum_reg;
  logic        [1:0]  s1_layer_reg;

  logic signed [33:0] sum_next;
  logic signed [33:0] bias_ext;
  logic               in_fire;

  assign in_fire  = in_valid & in_ready;
  assign bias_ext = {{18{bias[15]}}, bias};
  assign sum_next = {{2{acc[31]}}, acc} + (bias_ext <<< BIAS_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_sum_reg   <= '0;
      s1_layer_reg <= '0;
    end else begin
      s1_valid_reg <= in_fire;
      if (in_fire) begin
        s1_sum_reg   <= sum_next;
        s1_layer_reg <= layer;
      end
    end
  end

  // S2: combinational on the S1 register, result lands in the FIFO at the next edge
  logic        [4:0]  shamt;
  logic signed [34:0] sum_ext;
  logic signed [34:0] round_add;
  logic signed [34:0] rounded;
  logic signed [34:0] r_val;
  logic signed [15:0] res_data;
  logic               res_sat;

  always_comb begin
    shamt     = s1_layer_reg[1] ? 5'(SHIFT_FC) : 5'(SHIFT_CONV);
    sum_ext   = {s1_sum_reg[33], s1_sum_reg};
    round_add = (shamt == 5'd0) ? 35'sd0 : (35'sd1 <<< (shamt - 5'd1));
    rounded   = (sum_ext + round_add) >>> shamt;
    r_val     = rounded;
`ifdef RELU_EN
    if (!s1_layer_reg[1] && (rounded < 35'sd0))
      r_val = 35'sd0;
`else
`endif
    res_sat  = 1'b0;
    res_data = r_val[15:0];
    if (r_val > 35'sd32767) begin
      res_data = 16'sh7FFF;
      res_sat  = 1'b1;
    end else if (r_val < -35'sd32768) begin
      res_data = 16'sh8000;
      res_sat  = 1'b1;
    end
  end

  logic [15:0]      data_mem  [FIFO_DEPTH];
  logic [1:0]       layer_mem [FIFO_DEPTH];
  logic             sat_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [15:0]      sat_count_reg;
  logic [CW-1:0]    used;
  logic             wr_en;
  logic             rd_en;

  assign wr_en     = s1_valid_reg;
  assign out_valid = (count_reg != '0);
  assign rd_en     = out_valid & out_ready;
  // Credits cover both stored entries and the one possibly sitting in S1
  assign used      = CW'(count_reg) + CW'(s1_valid_reg);
  assign in_ready  = (used < CW'(FIFO_DEPTH));

  assign out_data  = out_valid ? $signed(data_mem[rd_ptr_reg]) : 16'sd0;
  assign out_layer = out_valid ? layer_mem[rd_ptr_reg] : 2'd0;
  assign out_sat   = out_valid ? sat_mem[rd_ptr_reg] : 1'b0;
  assign sat_count = sat_count_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_reg]  <= res_data;
      layer_mem[wr_ptr_reg] <= s1_layer_reg;
      sat_mem[wr_ptr_reg]   <= res_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      sat_count_reg <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (wr_en && !rd_en)
        count_reg <= count_reg + 1'b1;
      else if (!wr_en && rd_en)
        count_reg <= count_reg - 1'b1;
      if (wr_en && res_sat && (sat_count_reg != 16'hFFFF))
        sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_requant.sv
// Directed self-checking bench for mac_requant: rounding, ReLU/negative path,
// saturation, backpressure, back-to-back streaming and reset while in flight.
module tb_mac_requant;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] acc;
  logic signed [15:0] bias;
  logic        [1:0]  layer;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic        [1:0]  out_layer;
  logic               out_sat;
  logic        [15:0] sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  mac_requant dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc       (acc),
    .bias      (bias),
    .layer     (layer),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_layer (out_layer),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one input at a negedge; returns at the negedge two cycles later,
  // where the result is expected at the FIFO head.
  task automatic drive_one(input logic signed [31:0] a, input logic signed [15:0] b,
                           input logic [1:0] l);
    @(negedge clk);
    in_valid = 1'b1; acc = a; bias = b; layer = l;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    $display("txn in acc=%0d bias=%0d layer=%0d -> out valid=%0b data=%0d sat=%0b layer=%0d",
             a, b, l, out_valid, out_data, out_sat, out_layer);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc = '0; bias = '0; layer = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
    n_checks++; if (out_sat !== 1'b0 || out_layer !== 2'd0) begin n_fail++; $display("FAIL reset_tags: got sat=%b layer=%0d want 0/0", out_sat, out_layer); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; acc = 32'sd4736; bias = 16'sd0; layer = 2'd0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL round_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    $display("txn rounding out valid=%0b data=%0d sat=%0b", out_valid, out_data, out_sat);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL round_valid_latency: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 16'sd19) begin n_fail++; $display("FAIL round_data: got %0d want 19", out_data); end
    n_checks++; if (out_sat !== 1'b0 || out_layer !== 2'd0) begin n_fail++; $display("FAIL round_tags: got sat=%b layer=%0d want 0/0", out_sat, out_layer); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round_pop: got valid %b want 0", out_valid); end
  endtask

  task automatic test_negative_conv();
    logic signed [15:0] exp_v;
`ifdef RELU_EN
    exp_v = 16'sd0;
`else
    exp_v = -16'sd4;
`endif
    drive_one(-32'sd1000, 16'sd0, 2'd0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin n_fail++; $display("FAIL neg_conv_data: got valid=%b data=%0d want 1/%0d", out_valid, out_data, exp_v); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL neg_conv_sat: got %b want 0", out_sat); end
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL neg_conv_sat_count: got %0d want 0", sat_count); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    drive_one(32'sh7FFFFFFF, 16'sh7FFF, 2'd2);
    n_checks++; if (out_data !== 16'sd32767) begin n_fail++; $display("FAIL pos_sat_data: got %0d want 32767", out_data); end
    n_checks++; if (out_sat !== 1'b1 || out_layer !== 2'd2) begin n_fail++; $display("FAIL pos_sat_tags: got sat=%b layer=%0d want 1/2", out_sat, out_layer); end
    n_checks++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL pos_sat_count: got %0d want 1", sat_count); end
    @(negedge clk);
    drive_one(32'sh80000000, 16'sd0, 2'd2);
    n_checks++; if (out_data !== -16'sd32768) begin n_fail++; $display("FAIL neg_sat_data: got %0d want -32768", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL neg_sat_flag: got %b want 1", out_sat); end
    n_checks++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL neg_sat_count: got %0d want 2", sat_count); end
    @(negedge clk);
    // Reserved layer 3 uses the FC shift and keeps its tag
    drive_one(32'sd640, 16'sd0, 2'd3);
    n_checks++; if (out_data !== 16'sd3 || out_layer !== 2'd3) begin n_fail++; $display("FAIL layer3: got data=%0d layer=%0d want 3/3", out_data, out_layer); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int accepted;
    logic signed [15:0] got[$];
    accepted = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (accepted < 6) begin
        in_valid = 1'b1; acc = 32'((accepted * 100 + 5) * 256); bias = 16'sd0; layer = 2'd2;
        if (in_ready) accepted++;
      end else begin
        in_valid = 1'b0;
      end
    end
    n_checks++; if (accepted != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", accepted); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        got.push_back(out_data);
        $display("txn backpressure out data=%0d layer=%0d", out_data, out_layer);
      end
      if (got.size() == 6 && accepted == 6) break;
      if (accepted < 6) begin
        in_valid = 1'b1; acc = 32'((accepted * 100 + 5) * 256); bias = 16'sd0; layer = 2'd2;
        if (in_ready) accepted++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d results want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== 16'(i * 100 + 5)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i * 100 + 5); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_c;
    int last_c;
    logic signed [15:0] got[$];
    first_c = -1; last_c = -1;
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        got.push_back(out_data);
        if (first_c < 0) first_c = c;
        last_c = c;
        $display("txn b2b cycle=%0d out data=%0d", c, out_data);
      end
      if (c < 4) begin
        in_valid = 1'b1; acc = 32'((c * 1000 - 1500) * 256); bias = 16'sd0; layer = 2'd2;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (first_c != 2 || last_c != 5) begin n_fail++; $display("FAIL b2b_timing: got first=%0d last=%0d want 2/5", first_c, last_c); end
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== 16'(i * 1000 - 1500)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got[i], i * 1000 - 1500); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    seen = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; acc = 32'sh7FFFFFFF; bias = 16'sd0; layer = 2'd2;
    @(negedge clk);
    acc = 32'sd25600;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got valid %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0) begin n_fail++; $display("FAIL mid_out: got valid=%b data=%0d want 0/0", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL mid_sat_count: got %0d want 0", sat_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_emitted: got valid seen %b want 0", seen); end
    drive_one(32'sd4736, 16'sd0, 2'd1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd19 || out_layer !== 2'd1) begin n_fail++; $display("FAIL mid_recover: got valid=%b data=%0d layer=%0d want 1/19/1", out_valid, out_data, out_layer); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_negative_conv();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
